// File: rtl/lc3_writeback.sv
// LC-3 write-back sequencer: 2-entry in-order pending-write queue feeding the
// register-file write port, NZP condition-code tracking and operand bypass.
module lc3_writeback #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [2:0]  wb_dr,
   input  logic [15:0] wb_data,
   input  logic        wb_setcc,
   input  logic        rf_stall,
   output logic        rf_wr,
   output logic [2:0]  rf_dr,
   output logic [15:0] rf_din,
   input  logic [2:0]  sr1,
   input  logic [2:0]  sr2,
   input  logic [15:0] rf_d1,
   input  logic [15:0] rf_d2,
   output logic [15:0] d1,
   output logic [15:0] d2,
   output logic [2:0]  nzp,
   output logic [1:0]  pending
);

   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [2:0]  dr;
      logic [15:0] data;
      logic        setcc;
   } entry_t;

   entry_t           q [2];
   logic             head;
   logic             young;
   logic             tail;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   function automatic logic [2:0] cc_of(input logic [15:0] v);
      logic n;
      logic z;
      n = v[15];
      z = (v == 16'h0000);
      return {n, z, !n && !z};
   endfunction

   // ready depends only on registered occupancy, never on rf_stall or wb_valid
   assign wb_ready = (count != CNT_W'(DEPTH));
   assign rf_wr    = (count != '0) && !rf_stall;
   assign push     = wb_valid && wb_ready;
   assign pop      = rf_wr;
   assign young    = ~head;
   // with one entry left, a concurrent pop frees it; the new entry lands behind it
   assign tail     = head ^ count[0];
   assign rf_dr    = q[head].dr;
   assign rf_din   = q[head].data;
   assign pending  = count;

   // Queue payload storage; occupancy alone decides which slots are live.
   always_ff @(posedge clock) begin
      if (push) begin
         q[tail] <= '{dr: wb_dr, data: wb_data, setcc: wb_setcc};
      end
   end

   // Occupancy, head pointer and committed condition codes.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         head  <= 1'b0;
         count <= '0;
         nzp   <= 3'b010;
      end else begin
         if (pop) begin
            head <= ~head;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (pop && q[head].setcc) begin
            nzp <= cc_of(q[head].data);
         end
      end
   end

   // Youngest matching queued entry wins; the head stays visible in its commit cycle.
   always_comb begin
      d1 = rf_d1;
      d2 = rf_d2;
      if ((count != '0) && (q[head].dr == sr1)) d1 = q[head].data;
      if ((count != '0) && (q[head].dr == sr2)) d2 = q[head].data;
      if ((count == CNT_W'(2)) && (q[young].dr == sr1)) d1 = q[young].data;
      if ((count == CNT_W'(2)) && (q[young].dr == sr2)) d2 = q[young].data;
   end

endmodule
